// File: rtl/issue_lock_arbiter.sv
// Age-ordered lock arbiter: NUM_RES independent FREE/HELD locks; oldest issue ID wins a free resource.
// Latency: grant is combinational (0 cycles); owner_valid/owner_port/timeout register 1 cycle after grant.
// Backpressure: losers and non-owners see grant=0 and keep req asserted; held locks are never preempted.
module issue_lock_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int NUM_RES   = 2,
    parameter int ID_WIDTH  = 8,
    parameter int MAX_HOLD  = 0,
    parameter int RES_W     = (NUM_RES > 1) ? $clog2(NUM_RES) : 1,
    parameter int PORT_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req          [NUM_PORTS],
    input  logic [RES_W-1:0]    res_id       [NUM_PORTS],
    input  logic [ID_WIDTH-1:0] issue_id     [NUM_PORTS],
    input  logic                release_lock [NUM_PORTS],
    output logic                grant        [NUM_PORTS],
    output logic                owner_valid  [NUM_RES],
    output logic [PORT_W-1:0]   owner_port   [NUM_RES],
    output logic                timeout      [NUM_RES]
);

    typedef enum logic {
        FREE = 1'b0,
        HELD = 1'b1
    } state_t;

    // Hold counter only needs to reach MAX_HOLD, where it saturates.
    localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

    state_t              state_q [NUM_RES];
    state_t              state_d [NUM_RES];
    logic [PORT_W-1:0]   owner_q [NUM_RES];
    logic [PORT_W-1:0]   owner_d [NUM_RES];
    logic [CNT_W-1:0]    cnt_q   [NUM_RES];
    logic [CNT_W-1:0]    cnt_d   [NUM_RES];
    logic                to_q    [NUM_RES];
    logic                to_d    [NUM_RES];

    logic                win_vld  [NUM_RES];
    logic [PORT_W-1:0]   win_port [NUM_RES];
    logic [ID_WIDTH-1:0] win_id   [NUM_RES];
    logic                win_rel  [NUM_RES];
    logic                own_rel  [NUM_RES];

    // Serial-number compare: a is older than b when (a - b) is negative modulo 2^ID_WIDTH.
    function automatic logic is_older(input logic [ID_WIDTH-1:0] a, input logic [ID_WIDTH-1:0] b);
        logic [ID_WIDTH-1:0] diff;
        diff = a - b;
        return diff[ID_WIDTH-1];
    endfunction

    // Per-resource winner: scan ports low to high, replace only on strictly older so ties keep the lower port.
    always_comb begin
        for (int r = 0; r < NUM_RES; r++) begin
            win_vld[r]  = 1'b0;
            win_port[r] = '0;
            win_id[r]   = '0;
            win_rel[r]  = 1'b0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (req[p] && (res_id[p] == RES_W'(r))) begin
                    if (!win_vld[r] || is_older(issue_id[p], win_id[r])) begin
                        win_vld[r]  = 1'b1;
                        win_port[r] = PORT_W'(p);
                        win_id[r]   = issue_id[p];
                        win_rel[r]  = release_lock[p];
                    end
                end
            end
        end
    end

    // Release seen from the current owner of each resource; releases from other ports are ignored.
    always_comb begin
        for (int r = 0; r < NUM_RES; r++) begin
            own_rel[r] = 1'b0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if ((owner_q[r] == PORT_W'(p)) && release_lock[p]) begin
                    own_rel[r] = 1'b1;
                end
            end
        end
    end

    // Flash grant: owner of a held resource, or winner of a free one, for the resource the port selects.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            grant[p] = 1'b0;
            for (int r = 0; r < NUM_RES; r++) begin
                if (req[p] && (res_id[p] == RES_W'(r))) begin
                    if (state_q[r] == HELD) begin
                        grant[p] = (owner_q[r] == PORT_W'(p));
                    end else begin
                        grant[p] = win_vld[r] && (win_port[r] == PORT_W'(p));
                    end
                end
            end
        end
    end

    // Lock FSM next state, owner capture and hold-watchdog counting.
    always_comb begin
        for (int r = 0; r < NUM_RES; r++) begin
            state_d[r] = state_q[r];
            owner_d[r] = owner_q[r];
            cnt_d[r]   = cnt_q[r];
            to_d[r]    = to_q[r];
            case (state_q[r])
                FREE: begin
                    // A winner releasing in its grant cycle is a single-cycle use; lock stays free.
                    if (win_vld[r] && !win_rel[r]) begin
                        state_d[r] = HELD;
                        owner_d[r] = win_port[r];
                        cnt_d[r]   = '0;
                        to_d[r]    = 1'b0;
                    end
                end
                HELD: begin
                    if (own_rel[r]) begin
                        state_d[r] = FREE;
                        owner_d[r] = '0;
                        cnt_d[r]   = '0;
                        to_d[r]    = 1'b0;
                    end else if ((MAX_HOLD > 0) && (cnt_q[r] != HOLD_MAX)) begin
                        cnt_d[r] = cnt_q[r] + CNT_W'(1);
                        if ((cnt_q[r] + CNT_W'(1)) == HOLD_MAX) begin
                            to_d[r] = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d[r] = FREE;
                    owner_d[r] = '0;
                    cnt_d[r]   = '0;
                    to_d[r]    = 1'b0;
                end
            endcase
        end
    end

    // State registers; asynchronous reset frees every resource immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_RES; r++) begin
                state_q[r] <= FREE;
                owner_q[r] <= '0;
                cnt_q[r]   <= '0;
                to_q[r]    <= 1'b0;
            end
        end else begin
            for (int r = 0; r < NUM_RES; r++) begin
                state_q[r] <= state_d[r];
                owner_q[r] <= owner_d[r];
                cnt_q[r]   <= cnt_d[r];
                to_q[r]    <= to_d[r];
            end
        end
    end

    // Registered status straight from the lock state.
    always_comb begin
        for (int r = 0; r < NUM_RES; r++) begin
            owner_valid[r] = (state_q[r] == HELD);
            owner_port[r]  = owner_q[r];
            timeout[r]     = to_q[r];
        end
    end

endmodule

// File: tb/tb_issue_lock_arbiter.sv
// Directed bench for issue_lock_arbiter: 4 ports, 2 resources, 8-bit IDs, watchdog at 3 cycles.
// Inputs change 1 ns after posedge and outputs are compared 1 ns later, away from the clock edge.
// Fixed-length directed sequence; no open-ended waits on DUT events.
module tb_issue_lock_arbiter;

    logic       clk;
    logic       rst_n;
    logic       req          [4];
    logic [0:0] res_id       [4];
    logic [7:0] issue_id     [4];
    logic       release_lock [4];
    logic       grant        [4];
    logic       owner_valid  [2];
    logic [1:0] owner_port   [2];
    logic       timeout      [2];

    int checks = 0;
    int errors = 0;

    issue_lock_arbiter #(
        .NUM_PORTS (4),
        .NUM_RES   (2),
        .ID_WIDTH  (8),
        .MAX_HOLD  (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .res_id       (res_id),
        .issue_id     (issue_id),
        .release_lock (release_lock),
        .grant        (grant),
        .owner_valid  (owner_valid),
        .owner_port   (owner_port),
        .timeout      (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] gvec();
        return {grant[3], grant[2], grant[1], grant[0]};
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        for (int p = 0; p < 4; p++) begin
            req[p]          = 1'b0;
            res_id[p]       = 1'b0;
            issue_id[p]     = 8'd0;
            release_lock[p] = 1'b0;
        end
    endtask

    task automatic drive(input int p, input int r, input int id);
        req[p]      = 1'b1;
        res_id[p]   = 1'(r);
        issue_id[p] = 8'(id);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        clear_inputs();
        #1 rst_n = 1'b0;
        #2;
        chk("reset_owner_valid0", owner_valid[0], 0);
        chk("reset_owner_valid1", owner_valid[1], 0);
        chk("reset_owner_port0", owner_port[0], 0);
        chk("reset_timeout1", timeout[1], 0);
        chk("reset_grant", gvec(), 4'b0000);
        #14 rst_n = 1'b1;
        tick();

        // Age priority on res0: P1 (id 50) beats P0 (id 100).
        drive(0, 0, 100);
        drive(1, 0, 50);
        #1;
        chk("age_grant", gvec(), 4'b0010);
        chk("age_not_yet_held", owner_valid[0], 0);
        tick();
        chk("age_held", owner_valid[0], 1);
        chk("age_owner", owner_port[0], 1);
        release_lock[1] = 1'b1;
        #1;
        chk("age_release_cycle_grant", gvec(), 4'b0010);
        tick();
        req[1] = 1'b0;
        release_lock[1] = 1'b0;
        #1;
        chk("age_handover_grant", gvec(), 4'b0001);
        chk("age_freed", owner_valid[0], 0);
        tick();
        chk("age_new_owner_valid", owner_valid[0], 1);
        chk("age_new_owner", owner_port[0], 0);
        release_lock[0] = 1'b1;
        tick();
        clear_inputs();
        #1;
        chk("age_final_free", owner_valid[0], 0);

        // Parallel resources.
        drive(0, 0, 20);
        drive(1, 0, 10);
        drive(2, 1, 30);
        #1;
        chk("par_grant", gvec(), 4'b0110);
        tick();
        chk("par_owner0", owner_port[0], 1);
        chk("par_owner1", owner_port[1], 2);
        chk("par_valid1", owner_valid[1], 1);
        release_lock[1] = 1'b1;
        tick();
        req[1] = 1'b0;
        release_lock[1] = 1'b0;
        #1;
        chk("par_after_release_grant", gvec(), 4'b0101);
        tick();
        chk("par_owner0_new", owner_port[0], 0);
        chk("par_valid0_new", owner_valid[0], 1);
        chk("par_owner1_kept", owner_port[1], 2);
        release_lock[0] = 1'b1;
        release_lock[2] = 1'b1;
        tick();
        clear_inputs();
        #1;
        chk("par_free0", owner_valid[0], 0);
        chk("par_free1", owner_valid[1], 0);
        chk("par_free_port1", owner_port[1], 0);

        // Wrap-around on res0 (250 older than 3) and a tie on res1 (lower port wins).
        drive(0, 0, 250);
        drive(1, 0, 3);
        drive(2, 1, 7);
        drive(3, 1, 7);
        #1;
        chk("wrap_tie_grant", gvec(), 4'b0101);
        clear_inputs();
        #1;
        chk("wrap_idle_grant", gvec(), 4'b0000);
        tick();

        // No preemption: P3 holds res0, older P0 waits.
        drive(3, 0, 40);
        #1;
        chk("nopre_first", gvec(), 4'b1000);
        tick();
        chk("nopre_owner", owner_port[0], 3);
        drive(0, 0, 1);
        #1;
        chk("nopre_blocked", gvec(), 4'b1000);
        release_lock[0] = 1'b1;
        #1;
        chk("nopre_nonowner_release", gvec(), 4'b1000);
        tick();
        chk("nopre_owner_kept", owner_port[0], 3);
        release_lock[0] = 1'b0;
        release_lock[3] = 1'b1;
        #1;
        chk("nopre_release_cycle", gvec(), 4'b1000);
        tick();
        req[3] = 1'b0;
        release_lock[3] = 1'b0;
        #1;
        chk("nopre_handover", gvec(), 4'b0001);
        tick();
        chk("nopre_new_owner", owner_port[0], 0);
        release_lock[0] = 1'b1;
        tick();
        clear_inputs();
        #1;

        // Watchdog: timeout rises three edges after the acquiring edge and does not revoke.
        drive(1, 1, 5);
        tick();
        chk("wd_held", owner_valid[1], 1);
        chk("wd_t0", timeout[1], 0);
        tick();
        chk("wd_t1", timeout[1], 0);
        tick();
        chk("wd_t2", timeout[1], 0);
        tick();
        chk("wd_t3", timeout[1], 1);
        tick();
        chk("wd_sticky", timeout[1], 1);
        chk("wd_still_held", owner_valid[1], 1);
        chk("wd_still_granted", gvec(), 4'b0010);
        release_lock[1] = 1'b1;
        tick();
        chk("wd_cleared", timeout[1], 0);
        chk("wd_freed", owner_valid[1], 0);
        clear_inputs();
        #1;

        // Async reset in the middle of a hold with a raised timeout.
        drive(2, 1, 9);
        tick();
        tick();
        tick();
        tick();
        chk("ar_timeout_before", timeout[1], 1);
        chk("ar_owner_before", owner_port[1], 2);
        drive(0, 1, 20);
        drive(3, 1, 5);
        #1;
        chk("ar_grant_held", gvec(), 4'b0100);
        rst_n = 1'b0;
        #1;
        chk("ar_valid_cleared", owner_valid[1], 0);
        chk("ar_port_cleared", owner_port[1], 0);
        chk("ar_timeout_cleared", timeout[1], 0);
        rst_n = 1'b1;
        #1;
        chk("ar_oldest_grant", gvec(), 4'b1000);
        tick();
        chk("ar_new_owner", owner_port[1], 3);
        chk("ar_new_valid", owner_valid[1], 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/issue_lock_arbiter.md
# issue_lock_arbiter

Shared-resource lock controller that arbitrates NUM_RES identical resources (ALUs, memory banks, a global memory lock) among NUM_PORTS SIC ports by issue-ID age. The oldest issue ID wins. The winner receives a same-cycle ("flash") grant. The lock is held across cycles until the owner pulses release. It sits between the SIC request ports and the resource datapaths and drives their operand muxes via `owner_port`.

## Interface
- `NUM_PORTS`, default 4: number of requesting SIC ports.
- `NUM_RES`, default 2: number of lockable resources.
- `ID_WIDTH`, default 8: issue-ID width.
- `MAX_HOLD`, default 0: hold-cycle watchdog threshold; 0 disables the watchdog.
- `RES_W`, default `$clog2(NUM_RES)` with a minimum of 1: resource index width.
- `PORT_W`, default `$clog2(NUM_PORTS)` with a minimum of 1: port index width.

Ports (unpacked arrays indexed by port or resource):
- `clk`  in  1  clock; all state updates on posedge.
- `rst_n`  in  1  asynchronous active-low reset.
- `req[NUM_PORTS]`  in  1  port requests or holds its resource.
- `res_id[NUM_PORTS]`  in  RES_W  resource targeted by the port.
- `issue_id[NUM_PORTS]`  in  ID_WIDTH  age tag of the requesting instruction.
- `release_lock[NUM_PORTS]`  in  1  owner frees its lock at the next edge.
- `grant[NUM_PORTS]`  out  1  combinational; port may use `res_id[p]` this cycle.
- `owner_valid[NUM_RES]`  out  1  registered; resource is HELD.
- `owner_port[NUM_RES]`  out  PORT_W  registered; holder index, 0 when FREE.
- `timeout[NUM_RES]`  out  1  registered; hold exceeded MAX_HOLD.

## Operation
Each resource r has an independent two-state machine, FREE or HELD, plus an owner register and a hold counter.

**Age compare**
- a is older than b iff `(a - b)` computed in ID_WIDTH bits has its MSB set. This is serial-number arithmetic, so wrap-around is handled.
- Equal IDs: the lower port index wins.

**Winner of r**
- The oldest port p with `req[p]=1` and `res_id[p]=r`.
- Computed every cycle, combinationally.

**Grant**
- `grant[p]=1` iff `req[p]` and one of:
  - r=`res_id[p]` is HELD with `owner_port[r]=p`, or
  - r is FREE and p is the winner of r.
- While HELD, a non-owner never sees grant, even if it is older than the owner. There is no preemption.

**FREE to HELD**
- At posedge, if r is FREE, a winner p exists, and `release_lock[p]=0`: owner←p, counter←0.
- If the winner asserts release in that same FREE cycle, it is a single-cycle use and r stays FREE.

**HELD to FREE**
- At posedge, if `release_lock[owner]=1`: owner_valid←0, owner_port←0, counter←0, timeout←0.
- Release from a non-owner is ignored. Release when r is FREE (and the port is not the winner) is a no-op.

**Holding without requesting**
- An owner that drops `req` without releasing keeps the lock. Its grant is 0 while `req=0` and returns when `req` reasserts.

**Multiple resources per port**
- A port may own several resources. Its grant reflects only the resource currently selected by `res_id[p]`.

**Watchdog**
- While HELD and MAX_HOLD>0, the counter increments each cycle and saturates at MAX_HOLD.
- `timeout[r]` goes to 1 at the edge where counter reaches MAX_HOLD and stays 1 until release or reset.
- timeout is a status flag only; it does not revoke the lock.

## Timing
- **Reset (async, any time, including mid-hold):** all resources FREE; `owner_valid`=0, `owner_port`=0, counters=0, `timeout`=0. `grant` follows combinationally (the winner is granted immediately after reset deassertion).
- **Grant latency:** 0 cycles. Grant is valid in the same cycle as `req`, given settled inputs.
- **Ownership registration:** `owner_valid` rises 1 cycle after the first grant.
- **Handover:**
  - Release sampled at edge N frees r.
  - The next winner's flash grant appears in cycle N+1, after the edge.
  - There is no same-cycle handover; the old owner's grant persists through the release cycle.
- **Simultaneous events on one edge:** release of r and a request for another resource r' are independent and both take effect.

## Test plan
1. **Age priority, shared lock (NUM_RES=1):** P0 (id 100) and P1 (id 50) request → grant=0010. Then P1 releases for 1 cycle and drops req → next cycle grant=0001, owner_port=0.
2. **Parallel resources:** P0 (res0, id20), P1 (res0, id10), P2 (res1, id30) → grant=0110. After P1 releases, the cycle after release gives grant[0]=1 and owner_port[0]=0.
3. **Wrap-around:** ID_WIDTH=8, P0 id 250, P1 id 3 → P0 wins, grant=0001. Tie: P2 and P3 both id 7 on a free resource → P2 wins.
4. **No preemption:** P3 (id 40) holds res0; P0 (id 1) then requests res0 → grant[0]=0 until P3 releases, then P0 is granted the next cycle.
5. **Watchdog:** MAX_HOLD=3, P1 acquires and holds → timeout rises exactly 3 cycles after owner_valid rises and clears on the edge sampling release.
6. **Async reset mid-hold:** P2 owns res1 and rst_n pulses low between edges → owner_valid, owner_port and timeout go to 0 immediately, without waiting for a clock. After reset, the oldest requester is granted immediately.
